prog_control_param: RTL and testbench

PROG_CONTROL_PARAM -- requirements
Module: prog_control_param

---
 rtl/prog_pkg.sv | 20 ++
 rtl/prog_alu.sv | 31 +++
 rtl/prog_control_param.sv | 142 ++++++++++++++
 tb/tb_prog_control_param.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_pkg.sv
// Shared definitions for the tiny programmable controller: opcode and FSM state enums.
package prog_pkg;

    localparam int OPW = 4;

    typedef enum logic [OPW-1:0] {
        OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
        OP_LD  = 4'h4, OP_ST  = 4'h5, OP_LDI = 4'h6, OP_OUT = 4'h7,
        OP_MOV = 4'h8, OP_JMP = 4'h9, OP_JC  = 4'hA, OP_JNC = 4'hB,
        OP_JZ  = 4'hC, OP_JNZ = 4'hD, OP_IN  = 4'hE, OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/prog_alu.sv
// Combinational ALU for ADD/SUB/AND/OR; carry is the sum carry-out or the subtract borrow.
module prog_alu
    import prog_pkg::*;
#(
    parameter int DW = 4
) (
    input  opcode_e         op,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [DW-1:0]   result,
    output logic            carry
);

    logic [DW:0] wide;

    // One extra bit: carry-out for ADD, borrow (a < b) for SUB, zero for logic ops.
    always_comb begin
        wide = '0;
        case (op)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            default: wide = '0;
        endcase
    end

    assign result = wide[DW-1:0];
    assign carry  = wide[DW];

endmodule

// File: rtl/prog_control_param.sv
// Two-cycle-per-instruction accumulator machine with loadable program and data memories.
// Optional zero flag and JZ/JNZ enabled by defining PROG_ZFLAG_EN.
module prog_control_param
    import prog_pkg::*;
#(
    parameter int DW  = 4,
    parameter int AW  = 4,
    parameter int MAW = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [OPW+DW-1:0] prog_data,
    input  logic              start,
    input  logic [DW-1:0]     portin,
    output logic [DW-1:0]     portout,
    output logic              running,
    output logic              halted,
    output logic [AW-1:0]     pc,
    output state_e            dbg_state,
    output logic [DW-1:0]     dbg_y,
    output logic              dbg_carry
);

    // Strobes: prog_we and start are single-cycle level samples taken at posedge; prog_we is
    // honoured only in IDLE/HALT, start only in IDLE/HALT (both ignored while running).

    logic [OPW+DW-1:0] pm [2**AW];
    logic [DW-1:0]     dm [2**MAW];

    state_e            state, state_n;
    logic [OPW+DW-1:0] ir;
    logic [DW-1:0]     y, y1;
    logic              carry;
`ifdef PROG_ZFLAG_EN
    logic              zero;
`endif

    opcode_e           opc;
    logic [DW-1:0]     opnd;
    logic [DW-1:0]     alu_res;
    logic              alu_c;
    logic              taken;
    logic              y_upd;
    logic [DW-1:0]     y_nxt;
    logic [AW-1:0]     pc_nxt;

    assign opc  = opcode_e'(ir[OPW+DW-1:DW]);
    assign opnd = ir[DW-1:0];

    prog_alu #(.DW(DW)) u_alu (
        .op     (opc),
        .a      (y),
        .b      (y1),
        .result (alu_res),
        .carry  (alu_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_FETCH;
            S_FETCH: state_n = S_EXEC;
            S_EXEC:  state_n = (opc == OP_HLT) ? S_HALT : S_FETCH;
            S_HALT:  if (start) state_n = S_FETCH;
            default: state_n = S_IDLE;
        endcase
    end

    // Accumulator result; the set of Y-writing opcodes is also the zero-flag update set.
    always_comb begin
        taken = 1'b0;
        y_upd = 1'b0;
        y_nxt = y;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin y_nxt = alu_res; y_upd = 1'b1; end
            OP_LD:  begin y_nxt = dm[opnd[MAW-1:0]]; y_upd = 1'b1; end
            OP_LDI: begin y_nxt = opnd;              y_upd = 1'b1; end
            OP_IN:  begin y_nxt = portin;            y_upd = 1'b1; end
            OP_JMP: taken = 1'b1;
            OP_JC:  taken = carry;
            OP_JNC: taken = ~carry;
`ifdef PROG_ZFLAG_EN
            OP_JZ:  taken = zero;
            OP_JNZ: taken = ~zero;
`endif
            default: ;
        endcase
        if (opc == OP_HLT) pc_nxt = pc;
        else if (taken)    pc_nxt = opnd[AW-1:0];
        else               pc_nxt = pc + AW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= '0;
            ir      <= '0;
            y       <= '0;
            y1      <= '0;
            carry   <= 1'b0;
            portout <= '0;
`ifdef PROG_ZFLAG_EN
            zero    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_HALT: if (start) pc <= '0;
                S_FETCH: ir <= pm[pc];
                S_EXEC: begin
                    pc <= pc_nxt;
                    if (y_upd) y <= y_nxt;
                    if (opc == OP_ADD || opc == OP_SUB) carry <= alu_c;
                    if (opc == OP_MOV) y1 <= y;
                    if (opc == OP_OUT) portout <= y;
`ifdef PROG_ZFLAG_EN
                    if (y_upd) zero <= (y_nxt == '0);
`endif
                end
                default: ;
            endcase
        end
    end

    // Memories are never reset; an async reset drops state to IDLE, which blocks any ST write.
    always_ff @(posedge clk) begin
        if (prog_we && (state == S_IDLE || state == S_HALT)) pm[prog_addr] <= prog_data;
        if (state == S_EXEC && opc == OP_ST) dm[opnd[MAW-1:0]] <= y;
    end

    assign running   = (state == S_FETCH) || (state == S_EXEC);
    assign halted    = (state == S_HALT);
    assign dbg_state = state;
    assign dbg_y     = y;
    assign dbg_carry = carry;

endmodule

// File: tb/tb_prog_control_param.sv
// Scoreboard bench for prog_control_param: an instruction-level model predicts the
// architectural state seen at every EXEC cycle and at halt.
module tb_prog_control_param;
    import prog_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic       start = 1'b0;
    logic [3:0] portin = '0;
    logic [3:0] portout;
    logic       running, halted;
    logic [3:0] pc;
    state_e     dbg_state;
    logic [3:0] dbg_y;
    logic       dbg_carry;

    prog_control_param #(.DW(4), .AW(4), .MAW(4)) dut (
        .clk(clk), .reset_n(reset_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .portin(portin), .portout(portout),
        .running(running), .halted(halted), .pc(pc), .dbg_state(dbg_state),
        .dbg_y(dbg_y), .dbg_carry(dbg_carry)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {pc, portout, y, carry} at each EXEC cycle, before the instruction retires.
    logic [12:0] exp_q[$];

    // Reference model state
    logic [7:0] m_pm [16];
    int         m_dm [16];
    int         m_pc, m_y, m_y1, m_c, m_z, m_out;
    logic [7:0] prog_buf [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dbg_state == S_EXEC) begin
            logic [12:0] got, e;
            got = {pc, portout, dbg_y, dbg_carry};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL exec_unexpected: got %0h expected none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL exec_state: got %0h expected %0h", got, e);
                end
            end
        end
    end

    function automatic logic [7:0] ins(input int op, input int d);
        logic [7:0] w;
        w = {op[3:0], d[3:0]};
        return w;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_y = 0; m_y1 = 0; m_c = 0; m_z = 0; m_out = 0;
    endtask

    task automatic model_run(input int budget, output int n, output bit h);
        int op, d, s;
        bit tk;
        n = 0; h = 0; m_pc = 0;
        while (n < budget && !h) begin
            exp_q.push_back({m_pc[3:0], m_out[3:0], m_y[3:0], m_c[0]});
            op = int'(m_pm[m_pc][7:4]);
            d  = int'(m_pm[m_pc][3:0]);
            n++;
            tk = 0;
            case (op)
                0:  begin s = m_y + m_y1; m_c = (s > 15) ? 1 : 0; m_y = s % 16; end
                1:  begin m_c = (m_y < m_y1) ? 1 : 0; m_y = (m_y - m_y1 + 16) % 16; end
                2:  m_y = m_y & m_y1;
                3:  m_y = m_y | m_y1;
                4:  m_y = m_dm[d];
                5:  m_dm[d] = m_y;
                6:  m_y = d;
                7:  m_out = m_y;
                8:  m_y1 = m_y;
                9:  tk = 1;
                10: tk = (m_c == 1);
                11: tk = (m_c == 0);
`ifdef PROG_ZFLAG_EN
                12: tk = (m_z == 1);
                13: tk = (m_z == 0);
`endif
                14: m_y = int'(portin);
                15: h = 1;
                default: ;
            endcase
            if (op <= 4 || op == 6 || op == 14) m_z = (m_y == 0) ? 1 : 0;
            if (!h) m_pc = tk ? d : (m_pc + 1) % 16;
        end
    endtask

    task automatic clear_buf();
        for (int i = 0; i < 16; i++) prog_buf[i] = ins(15, 0);
    endtask

    task automatic load_buf();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            prog_we = 1'b1; prog_addr = i[3:0]; prog_data = prog_buf[i];
            m_pm[i] = prog_buf[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // abort_mode: 0 = reset in the FETCH after the budget, 1 = reset in the next EXEC.
    task automatic run_prog(input int budget, input int abort_mode, input bit disturb);
        int n, cyc;
        bit h;
        model_run(budget, n, h);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (h) begin
            cyc = 0;
            while (!halted && cyc < 2 * budget + 10) begin
                @(posedge clk);
                #1 cyc++;
                if (disturb && cyc == 3) begin
                    start = 1'b1; prog_we = 1'b1; prog_addr = 4'd2; prog_data = ins(15, 0);
                end
                if (disturb && cyc == 6) begin
                    start = 1'b0; prog_we = 1'b0;
                end
            end
            chk("halted", halted, 1);
            chk("halt_cycles", cyc, 2 * n);
            chk("halt_pc", pc, m_pc);
            chk("halt_portout", portout, m_out);
            chk("halt_carry", dbg_carry, m_c);
        end else begin
            repeat (2 * n + abort_mode) @(posedge clk);
            #1 reset_n = 1'b0;
            model_reset();
            #1;
            chk("abort_state_idle", dbg_state, S_IDLE);
            chk("abort_running", running, 0);
            chk("abort_pc", pc, 0);
            @(negedge clk);
            reset_n = 1'b1;
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", dbg_state, S_IDLE);
        chk("rst_pc", pc, 0);
        chk("rst_portout", portout, 0);
        chk("rst_running", running, 0);
        chk("rst_halted", halted, 0);
        chk("rst_y", dbg_y, 0);
        chk("rst_carry", dbg_carry, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Seed every data memory word so the model knows its contents.
        for (int half = 0; half < 2; half++) begin
            for (int i = 0; i < 8; i++) begin
                prog_buf[2*i]   = ins(6, $urandom_range(0, 15));
                prog_buf[2*i+1] = ins(5, half * 8 + i);
            end
            load_buf();
            run_prog(16, 0, 0);
        end

        // 3 + 5 = 8
        clear_buf();
        prog_buf[0] = ins(6, 3); prog_buf[1] = ins(8, 0); prog_buf[2] = ins(6, 5);
        prog_buf[3] = ins(0, 0); prog_buf[4] = ins(7, 0); prog_buf[5] = ins(15, 0);
        load_buf();
        run_prog(20, 0, 0);
        chk("add_portout", portout, 8);
        chk("add_carry", dbg_carry, 0);
        chk("add_pc", pc, 5);

        // F + 1 overflows, JC taken over the LDI 9
        clear_buf();
        prog_buf[0] = ins(6, 15); prog_buf[1] = ins(8, 0); prog_buf[2] = ins(6, 1);
        prog_buf[3] = ins(0, 0);  prog_buf[4] = ins(10, 7); prog_buf[5] = ins(6, 9);
        prog_buf[7] = ins(7, 0);
        load_buf();
        run_prog(20, 0, 0);
        chk("jc_portout", portout, 0);
        chk("jc_y", dbg_y, 0);
        chk("jc_carry", dbg_carry, 1);
        chk("jc_pc", pc, 8);

        // Store/load, then data memory survives reset
        clear_buf();
        prog_buf[0] = ins(6, 10); prog_buf[1] = ins(5, 2); prog_buf[2] = ins(6, 0);
        prog_buf[3] = ins(4, 2);  prog_buf[4] = ins(7, 0);
        load_buf();
        run_prog(20, 0, 0);
        chk("ldst_portout", portout, 10);
        do_reset();
        clear_buf();
        prog_buf[0] = ins(4, 2); prog_buf[1] = ins(7, 0);
        load_buf();
        run_prog(20, 0, 0);
        chk("dm_retained", portout, 10);

        // Wrap from the last address back to 0 through a non-jump
        clear_buf();
        prog_buf[0] = ins(9, 15); prog_buf[15] = ins(6, 7);
        load_buf();
        run_prog(6, 0, 0);

        // Zero-flag jump (NOP when the feature is absent)
        clear_buf();
        prog_buf[0] = ins(6, 0); prog_buf[1] = ins(12, 5); prog_buf[2] = ins(6, 9);
        prog_buf[3] = ins(7, 0); prog_buf[5] = ins(6, 5);  prog_buf[6] = ins(7, 0);
        load_buf();
        run_prog(20, 0, 0);
`ifdef PROG_ZFLAG_EN
        chk("jz_portout", portout, 5);
        chk("jz_pc", pc, 7);
`else
        chk("jz_portout", portout, 9);
        chk("jz_pc", pc, 4);
`endif

        // prog_we and start while running are ignored; rerun proves PM intact
        clear_buf();
        prog_buf[0] = ins(6, 1); prog_buf[1] = ins(8, 0);
        for (int i = 2; i < 6; i++) prog_buf[i] = ins(0, 0);
        prog_buf[6] = ins(7, 0);
        load_buf();
        run_prog(20, 0, 1);
        chk("disturb_portout", portout, 5);
        run_prog(20, 0, 0);
        chk("rerun_portout", portout, 5);
        chk("rerun_pc", pc, 7);

        // Reset during EXEC of ST must not write DM
        clear_buf();
        prog_buf[0] = ins(6, 9); prog_buf[1] = ins(5, 3);
        load_buf();
        run_prog(20, 0, 0);
        clear_buf();
        prog_buf[0] = ins(6, 5); prog_buf[1] = ins(5, 3);
        load_buf();
        run_prog(1, 1, 0);
        clear_buf();
        prog_buf[0] = ins(4, 3); prog_buf[1] = ins(7, 0);
        load_buf();
        run_prog(20, 0, 0);
        chk("st_abort_dm", portout, 9);

        // Random programs
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 16; i++) prog_buf[i] = 8'($urandom_range(0, 255));
            portin = 4'($urandom_range(0, 15));
            load_buf();
            run_prog(30, t % 2, 0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
